nf_mc_control_unit: RTL and testbench
=====================================

# nf_mc_control_unit

Multi-cycle control unit for the nanoFOX core, and the successor to the single-cycle combinational decoder. It sequences each instruction through fetch, decode, execute, memory and write-back states with a request/acknowledge handshake to the instruction and data memories. It decodes an extended RV32I subset: LUI, ADDI, SLLI, ADD, OR, BEQ, BNE, LW and SW. It drives all datapath selects, write enables and the PC update, and traps on illegal instructions or a memory timeout.

## Interface
- ALU_CODE_W, 4, width of `alu_code`. Codes: ADD=0, OR=1, SLL=2, LUI=3, SUB=4; must be ≥3.
- TIMEOUT, 255, maximum wait cycles for any memory acknowledge before trapping; must be ≥1.
- TO_W, 8, width of the wait counter; must satisfy 2^TO_W > TIMEOUT.

Ports (clock and reset first):
- clk  in  1  core clock; all state changes on the rising edge
- resetn  in  1  reset, synchronous and active-low
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  instruction data valid
- imem_rdata  in  32  fetched instruction
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store, 0 = load; valid while `dmem_req` is high
- dmem_ack  in  1  data access complete
- alu_zero  in  1  ALU result == 0
- instr_q  out  32  latched instruction, for immediate generation and register addressing
- imm_src  out  2  immediate type: i=0, u=1, b=2, s=3
- srcB_sel  out  1  0 = immediate, 1 = rs2
- alu_code  out  ALU_CODE_W  ALU operation
- rf_we  out  1  register file write enable
- wb_sel  out  1  write-back source: 0 = ALU, 1 = load data
- pc_we  out  1  PC update strobe, exactly one pulse per retired instruction
- pc_src  out  1  0 = PC+4, 1 = branch target
- trap  out  1  sticky fault flag
- state_o  out  3  current state, for debug

## Operation
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6. Encoding 7 is unreachable and recovers to IDLE.
- IDLE: entered on reset; moves unconditionally to FETCH on the next cycle.
- FETCH: `imem_req` is held high until `imem_ack`. On ack, `instr_q` <= `imem_rdata` and the FSM moves to DECODE.
- DECODE (one cycle): match {opcode, funct3, funct7}. Any unmatched encoding moves to TRAP. Supported encodings:
  - LUI 0110111, funct3/funct7 ignored
  - ADDI 0010011/000
  - SLLI 0010011/001, funct7 = 0000000
  - ADD 0110011/000, funct7 = 0000000
  - OR 0110011/110, funct7 = 0000000
  - BEQ 1100011/000
  - BNE 1100011/001
  - LW 0000011/010
  - SW 0100011/010
- EXEC: `alu_code`, `srcB_sel` and `imm_src` are driven from `instr_q`.
  - ALU and LUI instructions move to WB.
  - Branches use SUB with `srcB_sel`=1 and `imm_src`=b. They assert `pc_we` with `pc_src` = (BEQ ? alu_zero : !alu_zero), then move to FETCH.
  - LW and SW use ADD with `imm_src` = i (LW) or s (SW), then move to MEM.
- MEM: `dmem_req` is held high with `dmem_we` = (SW) until `dmem_ack`.
  - LW: on ack, move to WB.
  - SW: on ack, pulse `pc_we` with `pc_src`=0 and move to FETCH.
- WB: `rf_we`=1; `wb_sel`=1 for LW, else 0; `pc_we`=1 with `pc_src`=0; then move to FETCH.
- Wait counter: cleared on entry to FETCH or MEM and incremented each cycle the ack is low. If the count reaches TIMEOUT with no ack, the FSM moves to TRAP.
- TRAP: `trap`=1, every other output is 0, and the FSM stays in TRAP until reset.
- All control outputs default to 0 outside the states listed above; `instr_q` holds its last value.

## Timing
- Reset: synchronous. While `resetn`=0 at a clock edge, the next state is IDLE and `instr_q`, the wait counter and `trap` are cleared. All outputs read 0 during IDLE.
- Reset mid-operation (including during a pending `imem_req` or `dmem_req`) aborts the instruction with no `rf_we` or `pc_we`. Requests drop in the IDLE cycle.
- Outputs are Moore: a function of state and `instr_q`, except `pc_src`, which depends combinationally on `alu_zero` in EXEC.
- Cycles per instruction with zero-wait memory (ack in the first request cycle):
  - ALU/LUI: FETCH, DECODE, EXEC, WB = 4
  - branch: 3
  - LW: 5
  - SW: 4
- Each wait cycle of memory adds exactly 1 cycle.
- `imem_ack` is ignored outside FETCH and `dmem_ack` outside MEM. An ack arriving in the same cycle the counter reaches TIMEOUT wins: no trap.

## Test plan
- Reset, then ADDI x1,x0,5 (0x00500093) with ack in the first FETCH cycle:
  - `imm_src`=0, `alu_code`=0, `srcB_sel`=0 in EXEC
  - `rf_we`=1 and `pc_we`=1 in the WB cycle, 5 cycles after reset release.
- BNE (0x00209463) with `alu_zero`=0, then the same BNE with `alu_zero`=1:
  - `pc_we`=1 with `pc_src`=1 in the first case and `pc_src`=0 in the second
  - `rf_we` never asserts; 3 cycles each.
- LW (0x0000a103) with `dmem_ack` delayed 3 cycles:
  - `dmem_req` high for 4 cycles with `dmem_we`=0
  - WB has `wb_sel`=1 and `rf_we`=1; total 8 cycles.
- SW (0x0020a023):
  - `imm_src`=3, `dmem_we`=1
  - `pc_we` pulses on the ack cycle; `rf_we` stays 0.
- Illegal ADD with funct7=0100000 (0x40000033), and opcode 0x7F:
  - TRAP after DECODE, `trap`=1, sticky across 20 further cycles until `resetn`=0.
- `imem_ack` held low with TIMEOUT=4:
  - `trap` rises after exactly 4 wait cycles.
- Repeat the run with an ack landing on the 4th wait cycle: no trap.
- `resetn` pulsed low mid-MEM: no `pc_we`, IDLE then FETCH resumes.

Source files
------------

// File: rtl/nf_mc_control_unit.sv
// nanoFOX multi-cycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB with
// req/ack memory handshakes, drives datapath controls, traps on illegal ops or timeouts.
module nf_mc_control_unit #(
  parameter int ALU_CODE_W = 4,
  parameter int TIMEOUT    = 255,
  parameter int TO_W       = 8
)(
  input  logic                  clk,
  input  logic                  resetn,
  output logic                  imem_req,
  input  logic                  imem_ack,
  input  logic [31:0]           imem_rdata,
  output logic                  dmem_req,
  output logic                  dmem_we,
  input  logic                  dmem_ack,
  input  logic                  alu_zero,
  output logic [31:0]           instr_q,
  output logic [1:0]            imm_src,
  output logic                  srcB_sel,
  output logic [ALU_CODE_W-1:0] alu_code,
  output logic                  rf_we,
  output logic                  wb_sel,
  output logic                  pc_we,
  output logic                  pc_src,
  output logic                  trap,
  output logic [2:0]            state_o
);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
    S_MEM  = 3'd4, S_WB    = 3'd5, S_TRAP   = 3'd6, S_BAD  = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    I_LUI, I_ADDI, I_SLLI, I_ADD, I_OR, I_BEQ, I_BNE, I_LW, I_SW, I_ILL
  } op_t;

  localparam logic [ALU_CODE_W-1:0] ALU_ADD = ALU_CODE_W'(0);
  localparam logic [ALU_CODE_W-1:0] ALU_OR  = ALU_CODE_W'(1);
  localparam logic [ALU_CODE_W-1:0] ALU_SLL = ALU_CODE_W'(2);
  localparam logic [ALU_CODE_W-1:0] ALU_LUI = ALU_CODE_W'(3);
  localparam logic [ALU_CODE_W-1:0] ALU_SUB = ALU_CODE_W'(4);
  // Last no-ack cycle before the counter would hit TIMEOUT; an ack here still wins.
  localparam logic [TO_W-1:0]       TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          state;
  op_t             op;
  logic [TO_W-1:0] wait_cnt;
  logic [2:0]      f3;
  logic [6:0]      f7;

  assign f3 = instr_q[14:12];
  assign f7 = instr_q[31:25];

  always_comb begin
    op = I_ILL;
    case (instr_q[6:0])
      7'b0110111: op = I_LUI;
      7'b0010011: begin
        if (f3 == 3'b000) op = I_ADDI;
        else if (f3 == 3'b001 && f7 == 7'b0) op = I_SLLI;
      end
      7'b0110011: begin
        if (f7 == 7'b0 && f3 == 3'b000) op = I_ADD;
        else if (f7 == 7'b0 && f3 == 3'b110) op = I_OR;
      end
      7'b1100011: begin
        if (f3 == 3'b000) op = I_BEQ;
        else if (f3 == 3'b001) op = I_BNE;
      end
      7'b0000011: if (f3 == 3'b010) op = I_LW;
      7'b0100011: if (f3 == 3'b010) op = I_SW;
      default:    op = I_ILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= S_IDLE;
      instr_q  <= '0;
      wait_cnt <= '0;
    end else begin
      wait_cnt <= '0;
      case (state)
        S_IDLE:   state <= S_FETCH;
        S_FETCH: begin
          if (imem_ack) begin
            instr_q <= imem_rdata;
            state   <= S_DECODE;
          end else if (wait_cnt == TO_LAST) state <= S_TRAP;
          else wait_cnt <= wait_cnt + 1'b1;
        end
        S_DECODE: state <= (op == I_ILL) ? S_TRAP : S_EXEC;
        S_EXEC: begin
          case (op)
            I_BEQ, I_BNE: state <= S_FETCH;
            I_LW, I_SW:   state <= S_MEM;
            default:      state <= S_WB;
          endcase
        end
        S_MEM: begin
          if (dmem_ack) state <= (op == I_LW) ? S_WB : S_FETCH;
          else if (wait_cnt == TO_LAST) state <= S_TRAP;
          else wait_cnt <= wait_cnt + 1'b1;
        end
        S_WB:     state <= S_FETCH;
        S_TRAP:   state <= S_TRAP;
        default:  state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    imm_src  = 2'd0;
    srcB_sel = 1'b0;
    alu_code = ALU_ADD;
    rf_we    = 1'b0;
    wb_sel   = 1'b0;
    pc_we    = 1'b0;
    pc_src   = 1'b0;
    trap     = 1'b0;
    case (state)
      S_FETCH: imem_req = 1'b1;
      S_EXEC: begin
        case (op)
          I_LUI:  begin alu_code = ALU_LUI; imm_src = 2'd1; end
          I_SLLI: alu_code = ALU_SLL;
          I_ADD:  srcB_sel = 1'b1;
          I_OR:   begin alu_code = ALU_OR; srcB_sel = 1'b1; end
          I_BEQ, I_BNE: begin
            alu_code = ALU_SUB;
            srcB_sel = 1'b1;
            imm_src  = 2'd2;
            pc_we    = 1'b1;
            pc_src   = (op == I_BEQ) ? alu_zero : !alu_zero;
          end
          I_SW:   imm_src = 2'd3;
          default: ;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (op == I_SW);
        pc_we    = dmem_ack && (op == I_SW);
      end
      S_WB: begin
        rf_we  = 1'b1;
        wb_sel = (op == I_LW);
        pc_we  = 1'b1;
      end
      S_TRAP:  trap = 1'b1;
      default: ;
    endcase
  end

  assign state_o = state;
endmodule

// File: tb/tb_nf_mc_control_unit.sv
// Randomized instruction stream against a per-instruction outcome model
// (cycle count, strobes, selects) derived from the ISA subset and CPI rules.
module tb_nf_mc_control_unit;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        imem_req, imem_ack;
  logic [31:0] imem_rdata;
  logic        dmem_req, dmem_we, dmem_ack, alu_zero;
  logic [31:0] instr_q;
  logic [1:0]  imm_src;
  logic        srcB_sel;
  logic [3:0]  alu_code;
  logic        rf_we, wb_sel, pc_we, pc_src, trap;
  logic [2:0]  state_o;
  logic [14:0] ctl;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  nf_mc_control_unit #(.ALU_CODE_W(4), .TIMEOUT(TO), .TO_W(3)) dut (
    .clk(clk), .resetn(resetn),
    .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .alu_zero(alu_zero), .instr_q(instr_q), .imm_src(imm_src),
    .srcB_sel(srcB_sel), .alu_code(alu_code), .rf_we(rf_we), .wb_sel(wb_sel),
    .pc_we(pc_we), .pc_src(pc_src), .trap(trap), .state_o(state_o)
  );

  assign ctl = {imem_req, dmem_req, dmem_we, imm_src, srcB_sel, alu_code,
                rf_we, wb_sel, pc_we, pc_src, trap};

  // class index: 0 LUI,1 ADDI,2 SLLI,3 ADD,4 OR,5 BEQ,6 BNE,7 LW,8 SW,9 illegal
  int exp_alu [9] = '{3, 0, 2, 0, 1, 4, 4, 0, 0};
  int exp_srcb[9] = '{0, 0, 0, 1, 1, 1, 1, 0, 0};
  int exp_imm [9] = '{1, 0, 0, 0, 0, 2, 2, 0, 3};
  int base_cpi[9] = '{4, 4, 4, 4, 4, 3, 3, 5, 4};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int classify(input logic [31:0] ins);
    logic [6:0] opc = ins[6:0];
    logic [2:0] fn3 = ins[14:12];
    logic [6:0] fn7 = ins[31:25];
    if (opc == 7'h37) return 0;
    if (opc == 7'h13 && fn3 == 3'd0) return 1;
    if (opc == 7'h13 && fn3 == 3'd1 && fn7 == 7'd0) return 2;
    if (opc == 7'h33 && fn3 == 3'd0 && fn7 == 7'd0) return 3;
    if (opc == 7'h33 && fn3 == 3'd6 && fn7 == 7'd0) return 4;
    if (opc == 7'h63 && fn3 == 3'd0) return 5;
    if (opc == 7'h63 && fn3 == 3'd1) return 6;
    if (opc == 7'h03 && fn3 == 3'd2) return 7;
    if (opc == 7'h23 && fn3 == 3'd2) return 8;
    return 9;
  endfunction

  task automatic do_reset();
    resetn = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_state", state_o, 0);
    chk("rst_ctl", ctl, 0);
    chk("rst_instr_q", instr_q, 0);
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_to_fetch", {state_o, imem_req}, {3'd1, 1'b1});
  endtask

  // Entered at a negedge with the DUT in its first FETCH cycle; returns likewise.
  task automatic run_instr(input logic [31:0] ins, input int id, input int dd, input bit z);
    int  cls = classify(ins);
    bit  is_mem = (cls == 7 || cls == 8);
    bit  reach_exec = (id < TO) && (cls != 9);
    bit  exp_trap = (id >= TO) || (cls == 9) || (is_mem && dd >= TO);
    bit  exp_rf = !exp_trap && (cls <= 4 || cls == 7);
    int  exp_cyc, exp_dreq;
    int  cyc = 0, ireq = 0, dreq = 0, nrf = 0, npc = 0, nexec = 0, bad = 0;
    bit  pcsrc = 0, wbsel = 0, dwe = 0;
    logic [6:0] ex_ctl = '0;
    logic [2:0] st, prev;
    if (id >= TO)                exp_cyc = TO;
    else if (cls == 9)           exp_cyc = id + 2;
    else if (is_mem && dd >= TO) exp_cyc = id + 3 + TO;
    else                         exp_cyc = base_cpi[cls] + id + (is_mem ? dd : 0);
    exp_dreq = (reach_exec && is_mem) ? ((dd < TO) ? dd + 1 : TO) : 0;
    alu_zero = z;
    prev = 3'd1;
    for (int k = 0; k < 64; k++) begin
      if (k > 0) @(negedge clk);
      st = state_o;
      if (k > 0 && ((st == 3'd1 && prev != 3'd1) || st == 3'd6)) break;
      cyc++;
      imem_ack   = imem_req ? (ireq == id) : 1'($urandom_range(0, 1));
      imem_rdata = imem_req ? ins : $urandom;
      dmem_ack   = dmem_req ? (dreq == dd) : 1'($urandom_range(0, 1));
      if (imem_req) ireq++;
      if (dmem_req) dreq++;
      #1;
      if (dmem_req) dwe = dmem_we;
      if (st == 3'd3) begin nexec++; ex_ctl = {imm_src, srcB_sel, alu_code}; end
      if (rf_we) begin nrf++; wbsel = wb_sel; end
      if (pc_we) begin npc++; pcsrc = pc_src; end
      prev = st;
    end
    chk("cycles", cyc, exp_cyc);
    chk("imem_req_cycles", ireq, (id < TO) ? id + 1 : TO);
    chk("dmem_req_cycles", dreq, exp_dreq);
    chk("trap", trap, exp_trap);
    chk("rf_we_count", nrf, exp_rf);
    chk("pc_we_count", npc, !exp_trap);
    chk("exec_cycles", nexec, reach_exec);
    if (reach_exec)
      chk("exec_ctl", ex_ctl, {2'(exp_imm[cls]), 1'(exp_srcb[cls]), 4'(exp_alu[cls])});
    if (!exp_trap)
      chk("pc_src", pcsrc, (cls == 5) ? z : (cls == 6) ? !z : 1'b0);
    if (exp_rf) chk("wb_sel", wbsel, cls == 7);
    if (exp_dreq > 0) chk("dmem_we", dwe, cls == 8);
    if (id < TO) chk("instr_q", instr_q, ins);
    if (exp_trap) begin
      for (int k = 0; k < 20; k++) begin
        imem_ack = 1'($urandom_range(0, 1)); dmem_ack = 1'($urandom_range(0, 1));
        imem_rdata = $urandom; alu_zero = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (ctl !== 15'd1 || state_o !== 3'd6) bad++;
      end
      chk("trap_sticky_bad_cycles", bad, 0);
      do_reset();
    end
  endtask

  task automatic mem_reset();
    int strobes = 0;
    imem_rdata = 32'h0000a103;
    dmem_ack = 1'b0;
    for (int k = 0; k < 10 && state_o != 3'd4; k++) begin
      imem_ack = imem_req;
      #1;
      if (pc_we || rf_we) strobes++;
      @(negedge clk);
    end
    chk("mid_mem_reached", state_o, 4);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    if (pc_we || rf_we) strobes++;
    @(negedge clk);
    chk("mid_mem_idle", {state_o, ctl}, {3'd0, 15'd0});
    chk("mid_mem_strobes", strobes, 0);
    resetn = 1'b1;
    @(negedge clk);
    chk("mid_mem_refetch", {state_o, imem_req}, {3'd1, 1'b1});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] ins;
    int sel, id, dd;
    resetn = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = '0; alu_zero = 1'b0;
    do_reset();
    run_instr(32'h00500093, 0, 0, 1'b0);
    run_instr(32'h00209463, 0, 0, 1'b0);
    run_instr(32'h00209463, 0, 0, 1'b1);
    run_instr(32'h0000a103, 0, 3, 1'b0);
    run_instr(32'h0020a023, 1, 2, 1'b0);
    run_instr(32'h40000033, 0, 0, 1'b0);
    run_instr(32'h0000007f, 0, 0, 1'b0);
    run_instr(32'h00500093, TO, 0, 1'b0);
    run_instr(32'h00500093, TO - 1, 0, 1'b0);
    run_instr(32'h0000a103, 0, TO - 1, 1'b0);
    run_instr(32'h0020a023, 0, TO, 1'b0);
    mem_reset();
    for (int n = 0; n < 80; n++) begin
      ins = $urandom;
      sel = $urandom_range(0, 10);
      case (sel)
        0: ins[6:0] = 7'h37;
        1: begin ins[6:0] = 7'h13; ins[14:12] = 3'd0; end
        2: begin ins[6:0] = 7'h13; ins[14:12] = 3'd1; ins[31:25] = 7'd0; end
        3: begin ins[6:0] = 7'h33; ins[14:12] = 3'd0; ins[31:25] = 7'd0; end
        4: begin ins[6:0] = 7'h33; ins[14:12] = 3'd6; ins[31:25] = 7'd0; end
        5: begin ins[6:0] = 7'h63; ins[14:12] = 3'd0; end
        6: begin ins[6:0] = 7'h63; ins[14:12] = 3'd1; end
        7: begin ins[6:0] = 7'h03; ins[14:12] = 3'd2; end
        8: begin ins[6:0] = 7'h23; ins[14:12] = 3'd2; end
        9: ;
        default: begin ins[6:0] = 7'h33; ins[14:12] = 3'd0; ins[31:25] = 7'h20; end
      endcase
      id = ($urandom_range(0, 9) == 0) ? TO + $urandom_range(0, 1) : $urandom_range(0, TO - 1);
      dd = ($urandom_range(0, 9) == 0) ? TO + $urandom_range(0, 1) : $urandom_range(0, TO - 1);
      run_instr(ins, id, dd, 1'($urandom_range(0, 1)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
